mux_nto1_rr_reg: RTL
====================

// Module: mux_nto1_rr_reg
// PURPOSE
//  Parametrised N:1 word multiplexer with a registered, valid/ready output stage.
//  Generalises the fixed 8:1 one-bit mux in two directions: arbitrary width and input count,
//  plus a round-robin arbitration mode alongside direct select.
//  Used to funnel multiple producers (writeback sources, debug/trace taps) into one consumer.
// PARAMETERS
//  N      8   number of input channels, 2..32, need not be a power of two
//  W      32  data width per channel
//  SELW   $clog2(N)  width of sel/out_src (localparam, derived)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset, sampled on clk rising edge
//  mode       in   1      0 = direct select via sel, 1 = round-robin over in_valid
//  sel        in   SELW   channel index used in mode 0
//  in_data    in   N*W    channel i at [i*W +: W]
//  in_valid   in   N      per-channel valid
//  in_ready   out  N      per-channel ready (combinational)
//  out_data   out  W      registered output word
//  out_src    out  SELW   index of channel that supplied out_data
//  out_valid  out  1      out_data/out_src hold a word
//  out_ready  in   1      consumer accepts word this cycle
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_src=0, rr_ptr=0. Held word discarded.
//  load_en = !out_valid || out_ready (one-entry pipe; full throughput when consumer always ready).
//  Mode 0: grant = sel. If sel >= N, no grant and in_ready = 0.
//  Mode 1: grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
//  No grant if in_valid == 0.
//  in_ready[i] = load_en && grant_ok && (i == grant); all other bits 0. At most one bit is set.
//  Transfer on input i when in_valid[i] && in_ready[i].
//  On that edge: out_data <= in word i, out_src <= i, out_valid <= 1.
//  Mode 1 also updates rr_ptr <= (i+1) mod N, wrapping N-1 -> 0.
//  If no transfer and out_ready && out_valid: out_valid <= 0.
//  out_data and out_src keep their last values.
//  Otherwise out_* hold. out_data/out_src must not change while out_valid && !out_ready.
//  Latency: exactly 1 cycle from input transfer to out_valid.
//  Simultaneous output drain and new load in the same cycle is supported (back-to-back words).
//  rr_ptr changes only on a mode-1 transfer. It is retained across mode switches.
//  mode/sel are sampled combinationally each cycle. A change affects only the current cycle's grant.
//  in_ready depends on in_valid in mode 1 only; never on out_data.
// STRUCTURE
//  Shared package: none required; SELW is a localparam from $clog2(N) (min 1).
//  Sub-module mux_tree_nto1 (#N,#W): combinational N:1 word mux with binary select.
//  Built as a log2 tree of 2:1 stages; out-of-range index yields 0.
//  Top level contains the rr priority scan, ready generation, rr_ptr and the output register.
// TESTING
//  1 N=8,W=32, mode0, sel=3, in_valid=8'h08, in3=32'hDEADBEEF, out_ready=1
//    -> in_ready=8'h08; next cycle out_valid=1, out_data=DEADBEEF, out_src=3.
//  2 Backpressure: out_valid=1, out_ready=0, new in_valid[3]=1
//    -> in_ready=0, out_data held.
//    Raise out_ready -> new word loads same edge the old drains.
//  3 mode1, in_valid=8'hFF held, out_ready=1, 10 cycles
//    -> out_src sequence 0,1,...,7,0,1; rr_ptr wraps 7->0.
//  4 mode1, rr_ptr=6, in_valid=8'h05 -> grant 0 (wrap scan), then rr_ptr=1 -> next grant 2.
//  5 N=5, mode0, sel=6, in_valid=5'h1F -> in_ready=0, out_valid stays 0.
//  6 Reset mid-stream: out_valid=1, out_ready=0, rst_n=0 one cycle
//    -> out_valid=0, out_data=0, out_src=0, rr_ptr=0; mode1 next grants from channel 0.

Source files
------------

// File: rtl/mux_nto1_rr_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr_reg_pkg
//   Shared definitions for the N:1 registered word multiplexer.
//   - mode_e   : arbitration mode (direct select / round-robin)
//   - selw_of  : width of a channel index for n channels (never below 1)
// ---------------------------------------------------------------------------
package mux_nto1_rr_reg_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // A two-channel mux still needs one select bit.
  function automatic int selw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_rr_reg_if.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr_reg_if
//   Bundles the producer-side channel bus, the mode/select controls and the
//   consumer-side valid/ready output of mux_nto1_rr_reg.
//   Signals:
//     mode      0 = direct select via sel, 1 = round-robin over in_valid
//     sel       channel index used in direct mode
//     in_data   N*W packed channel words, channel i at [i*W +: W]
//     in_valid  per-channel valid
//     in_ready  per-channel ready (driven by the mux)
//     out_data  registered output word
//     out_src   index of the channel that supplied out_data
//     out_valid out_data/out_src hold a word
//     out_ready consumer accepts the word this cycle
//   Modports: master = environment (producers + consumer), slave = mux.
// ---------------------------------------------------------------------------
interface mux_nto1_rr_reg_if
  import mux_nto1_rr_reg_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
);
  localparam int SELW = selw_of(N);

  logic            mode;
  logic [SELW-1:0] sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_src;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/mux_nto1_rr_reg_mux_tree.sv
// ---------------------------------------------------------------------------
// mux_tree_nto1
//   Combinational N:1 word multiplexer with binary select, built as a tree
//   of 2:1 stages. Level 0 holds the inputs padded up to a power of two with
//   zero words, so any index >= N selects 0.
//   Ports:
//     in_data   N*W packed words, word i at [i*W +: W]
//     sel       binary word index
//     out_data  selected word (0 when sel >= N)
// ---------------------------------------------------------------------------
module mux_tree_nto1
  import mux_nto1_rr_reg_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic [N*W-1:0]          in_data,
  input  logic [selw_of(N)-1:0]   sel,
  output logic [W-1:0]            out_data
);

  localparam int SELW = selw_of(N);
  localparam int P    = 1 << SELW;

  // Level s holds P>>s words; level s merges pairs of level s-1 on sel[s-1].
  for (genvar s = 0; s <= SELW; s++) begin : g_lvl
    logic [W-1:0] w [0:(P>>s)-1];
    if (s == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_in
        if (i < N) begin : g_real
          assign w[i] = in_data[i*W +: W];
        end else begin : g_pad
          assign w[i] = '0;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < (P>>s); j++) begin : g_mux
        assign w[j] = sel[s-1] ? g_lvl[s-1].w[2*j+1] : g_lvl[s-1].w[2*j];
      end
    end
  end

  assign out_data = g_lvl[SELW].w[0];

endmodule

// File: rtl/mux_nto1_rr_reg.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr_reg
//   N:1 word multiplexer with a one-entry registered valid/ready output.
//   Direct mode grants channel sel; round-robin mode grants the first valid
//   channel scanning upward from rr_ptr with wrap. A granted channel sees
//   in_ready whenever the output register can load (empty or draining).
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (clears output register and rr_ptr)
//     bus    mux_nto1_rr_reg_if.slave (mode, sel, channel bus, output bus)
// ---------------------------------------------------------------------------
module mux_nto1_rr_reg
  import mux_nto1_rr_reg_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_nto1_rr_reg_if.slave   bus
);

  localparam int SELW = selw_of(N);
  localparam logic [SELW:0]   N_L  = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N-1);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_grant;
  logic            rr_found;
  logic [SELW:0]   scan_idx;
  logic [SELW-1:0] grant;
  logic            grant_ok;
  logic            load_en;
  logic            xfer;
  logic [W-1:0]    mux_word;

  logic [W-1:0]    data_p1;
  logic [SELW-1:0] src_p1;
  logic            vld_p1;

  // ---- stage p0: arbitration, ready generation and word select ----
  assign load_en = !vld_p1 || bus.out_ready;

  // Priority scan starting at rr_ptr; scan_idx stays below 2N so a single
  // conditional subtract performs the modulo.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SELW+1)'(k);
      if (scan_idx >= N_L) scan_idx = scan_idx - N_L;
      if (!rr_found && bus.in_valid[scan_idx[SELW-1:0]]) begin
        rr_found = 1'b1;
        rr_grant = scan_idx[SELW-1:0];
      end
    end
  end

  always_comb begin
    if (mode_e'(bus.mode) == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = bus.sel;
      grant_ok = ({1'b0, bus.sel} < N_L);
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = load_en && grant_ok && (grant == SELW'(i));
    end
  end

  assign xfer = |(bus.in_valid & bus.in_ready);

  mux_tree_nto1 #(.N(N), .W(W)) u_tree (
    .in_data  (bus.in_data),
    .sel      (grant),
    .out_data (mux_word)
  );

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (xfer) begin
        data_p1 <= mux_word;
        src_p1  <= grant;
        vld_p1  <= 1'b1;
        if (mode_e'(bus.mode) == MODE_RR)
          rr_ptr <= (grant == LAST) ? '0 : grant + SELW'(1);
      end else if (bus.out_ready && vld_p1) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;

endmodule
